// File: rtl/popcount_stream_checker.sv
// Streaming popcount classifier: accepts an N-bit word, counts its set bits M per clock,
// then holds the count and none/one/K/all flags until the consumer takes them.
module popcount_stream_checker #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 2,
  parameter int unsigned K = 3,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  number,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          none_set,
  output logic          exactly_one,
  output logic          exactly_k,
  output logic          all_set
);

  localparam int unsigned C = (N + M - 1) / M;

  // Refuse to elaborate with an illegal parameter set.
  generate
    if (N < 2 || M < 1 || M > N || K > N) begin : g_bad_params
      $error("popcount_stream_checker: illegal parameters N=%0d M=%0d K=%0d", N, M, K);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [CW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          none_q, none_d;
  logic          one_q, one_d;
  logic          k_q, k_d;
  logic          all_q, all_d;
  logic          out_valid_q, out_valid_d;

  logic [CW-1:0] chunk_pop;
  logic [CW-1:0] acc_sum;

  // Population of the low M bits; zero fill makes the padded final chunk harmless.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < int'(M); i++) begin
      chunk_pop = chunk_pop + CW'(shreg_q[i]);
    end
    acc_sum = acc_q + chunk_pop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      chunk_q     <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      none_q      <= 1'b0;
      one_q       <= 1'b0;
      k_q         <= 1'b0;
      all_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      chunk_q     <= chunk_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      none_q      <= none_d;
      one_q       <= one_d;
      k_q         <= k_d;
      all_q       <= all_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    chunk_d     = chunk_q;
    acc_d       = acc_q;
    count_d     = count_q;
    none_d      = none_q;
    one_d       = one_q;
    k_d         = k_q;
    all_d       = all_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = number;
          chunk_d = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        shreg_d = shreg_q >> M;
        acc_d   = acc_sum;
        if (chunk_q == CW'(C - 1)) begin
          count_d     = acc_sum;
          none_d      = (acc_sum == CW'(0));
          one_d       = (acc_sum == CW'(1));
          k_d         = (acc_sum == CW'(K));
          all_d       = (acc_sum == CW'(N));
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          chunk_d = chunk_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE) & ~reset;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign none_set    = none_q;
  assign exactly_one = one_q;
  assign exactly_k   = k_q;
  assign all_set     = all_q;

endmodule

// File: tb/tb_popcount_stream_checker.sv
// Directed bench for popcount_stream_checker: default 8/2/3 instance plus a padded 7/3/0 instance.
module tb_popcount_stream_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, out_ready;
  logic [7:0] number;
  logic       in_ready, out_valid;
  logic [3:0] count;
  logic       none_set, exactly_one, exactly_k, all_set;

  logic       in_valid2, out_ready2;
  logic [6:0] number2;
  logic       in_ready2, out_valid2;
  logic [2:0] count2;
  logic       none2, one2, k2, all2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  popcount_stream_checker #(.N(8), .M(2), .K(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .number(number), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .none_set(none_set), .exactly_one(exactly_one),
    .exactly_k(exactly_k), .all_set(all_set)
  );

  popcount_stream_checker #(.N(7), .M(3), .K(0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .number(number2), .out_valid(out_valid2), .out_ready(out_ready2),
    .count(count2), .none_set(none2), .exactly_one(one2),
    .exactly_k(k2), .all_set(all2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes one word into the default instance and collects its result (no comparisons).
  task automatic run_word(input logic [7:0] w, output int lat, output logic [3:0] cnt,
                          output logic [3:0] flg);
    in_valid = 1'b1;
    number   = w;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    cnt = count;
    flg = {none_set, exactly_one, exactly_k, all_set};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs got out_valid=%b in_ready=%b exp 0/0", out_valid, in_ready);
    end
    total++;
    if ({count, none_set, exactly_one, exactly_k, all_set} !== 8'h00) begin
      bad++;
      $display("FAIL reset_out got=%h exp=00", {count, none_set, exactly_one, exactly_k, all_set});
    end
    tick();
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || in_ready2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_release got in_ready=%b/%b exp 1/1", in_ready, in_ready2);
    end
  endtask

  task automatic test_single_bit();
    int lat; logic [3:0] cnt; logic [3:0] flg;
    run_word(8'b0001_0000, lat, cnt, flg);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL latency got=%0d exp=4", lat); end
    total++;
    if (cnt !== 4'd1) begin bad++; $display("FAIL one_count got=%0d exp=1", cnt); end
    total++;
    if (flg !== 4'b0100) begin bad++; $display("FAIL one_flags got=%b exp=0100", flg); end
  endtask

  task automatic test_extremes();
    int lat; logic [3:0] cnt; logic [3:0] flg;
    run_word(8'hFF, lat, cnt, flg);
    total++;
    if (cnt !== 4'd8 || flg !== 4'b0001) begin
      bad++; $display("FAIL all_ones got cnt=%0d flags=%b exp 8/0001", cnt, flg);
    end
    run_word(8'h00, lat, cnt, flg);
    total++;
    if (cnt !== 4'd0 || flg !== 4'b1000) begin
      bad++; $display("FAIL all_zeros got cnt=%0d flags=%b exp 0/1000", cnt, flg);
    end
    run_word(8'b1100_0000, lat, cnt, flg);
    total++;
    if (cnt !== 4'd2 || flg !== 4'b0000) begin
      bad++; $display("FAIL two_high got cnt=%0d flags=%b exp 2/0000", cnt, flg);
    end
  endtask

  task automatic test_exactly_k();
    int lat; logic [3:0] cnt; logic [3:0] flg;
    run_word(8'b1010_0100, lat, cnt, flg);
    total++;
    if (cnt !== 4'd3 || flg !== 4'b0010) begin
      bad++; $display("FAIL k_match got cnt=%0d flags=%b exp 3/0010", cnt, flg);
    end
    run_word(8'b0111_1000, lat, cnt, flg);
    total++;
    if (cnt !== 4'd4 || flg !== 4'b0000) begin
      bad++; $display("FAIL k_miss got cnt=%0d flags=%b exp 4/0000", cnt, flg);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_valid = 1'b1;
    number   = 8'b1010_0100;
    tick();
    number   = 8'hFF;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || count !== 4'd3 ||
          {none_set, exactly_one, exactly_k, all_set} !== 4'b0010) begin
        bad++;
        $display("FAIL hold%0d got rdy=%b vld=%b cnt=%0d flags=%b exp 0/1/3/0010", i, in_ready,
                 out_valid, count, {none_set, exactly_one, exactly_k, all_set});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL release got rdy=%b vld=%b exp 1/0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL accept_next got rdy=%b exp 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 4 || count !== 4'd8 || all_set !== 1'b1) begin
      bad++; $display("FAIL second_word got lat=%0d cnt=%0d all=%b exp 4/8/1", lat, count, all_set);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    in_valid = 1'b1;
    number   = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset got vld=%b cnt=%0d rdy=%b exp 0/0/0", out_valid, count, in_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL stale_result got=%b exp=0", seen); end
    end
  endtask

  task automatic test_padded_width();
    int lat;
    in_valid2 = 1'b1;
    number2   = 7'h7F;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 3 || count2 !== 3'd7 || {none2, one2, k2, all2} !== 4'b0001) begin
      bad++; $display("FAIL pad_all got lat=%0d cnt=%0d flags=%b exp 3/7/0001", lat, count2,
                      {none2, one2, k2, all2});
    end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    in_valid2 = 1'b1;
    number2   = 7'h00;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if (count2 !== 3'd0 || {none2, one2, k2, all2} !== 4'b1010) begin
      bad++; $display("FAIL pad_zero_k got cnt=%0d flags=%b exp 0/1010", count2, {none2, one2, k2, all2});
    end
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; number = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; number2 = '0;
    reset = 1'b0;
    #2;
    test_reset();
    test_single_bit();
    test_extremes();
    test_exactly_k();
    test_back_to_back();
    test_reset_mid_scan();
    test_padded_width();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
